// File: rtl/spd_slew_pkg.sv
// Shared types and helpers for the slew-limited motor command stage.
package spd_slew_pkg;

  // Per-channel sequencing: settled, ramping, braking for a reversal, flipping.
  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RAMP  = 2'd1,
    DECEL = 2'd2,
    FLIP  = 2'd3
  } ch_state_t;

  // Update-tick period used when fast_sim is set.
  localparam int FAST_TICK_DIV = 8;

  // Move cur toward tgt by at most step. The result always lies between cur and
  // tgt, so it can neither overshoot nor wrap.
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] step);
    logic [31:0] diff;
    if (tgt >= cur) begin
      diff = tgt - cur;
      return (diff > step) ? (cur + step) : tgt;
    end else begin
      diff = cur - tgt;
      return (diff > step) ? (cur - step) : tgt;
    end
  endfunction

endpackage

// File: rtl/spd_slew_ch.sv
// One motor channel: target latch, slewed speed/direction outputs and the
// reversal sequencer (decelerate to zero, flip, ramp back up).
module spd_slew_ch
  import spd_slew_pkg::*;
#(
  parameter int SPD_W     = 11,
  parameter int SLEW_STEP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwr_up_i,
  input  logic             tick_i,
  input  logic             cmd_vld_i,
  input  logic             rider_off_i,
  input  logic [SPD_W-1:0] cmd_spd_i,
  input  logic             cmd_rev_i,
  output logic [SPD_W-1:0] out_spd_o,
  output logic             out_rev_o,
  output logic             rev_pend_o,
  output logic             settled_o
);

  ch_state_t        state_q, state_d;
  logic [SPD_W-1:0] out_spd_q, out_spd_d;
  logic [SPD_W-1:0] tgt_spd_q, tgt_spd_d;
  logic             out_rev_q, out_rev_d;
  logic             tgt_rev_q, tgt_rev_d;
  logic [SPD_W-1:0] toward_spd;
  logic [SPD_W-1:0] decel_spd;

  assign toward_spd = SPD_W'(step_toward(32'(out_spd_q), 32'(tgt_spd_q), SLEW_STEP));
  assign decel_spd  = SPD_W'(step_toward(32'(out_spd_q), 32'd0, SLEW_STEP));

  // Next-state: power kill first, then the tick-driven sequencer, then target latch.
  // The sequencer reads the registered targets, so a same-cycle command only
  // takes effect from the following tick.
  always_comb begin
    state_d   = state_q;
    out_spd_d = out_spd_q;
    out_rev_d = out_rev_q;
    tgt_spd_d = tgt_spd_q;
    tgt_rev_d = tgt_rev_q;
    if (!pwr_up_i) begin
      state_d   = HOLD;
      out_spd_d = '0;
      out_rev_d = 1'b0;
      tgt_spd_d = '0;
      tgt_rev_d = 1'b0;
    end else begin
      if (tick_i) begin
        if (state_q == FLIP) begin
          out_rev_d = tgt_rev_q;
          state_d   = (tgt_spd_q == '0) ? HOLD : RAMP;
        end else if (out_rev_q != tgt_rev_q) begin
          // Zero speed seen on entry to a braking tick means it is safe to flip.
          if ((state_q == DECEL) && (out_spd_q == '0)) begin
            state_d = FLIP;
          end else begin
            out_spd_d = decel_spd;
            state_d   = DECEL;
          end
        end else begin
          out_spd_d = toward_spd;
          state_d   = (toward_spd == tgt_spd_q) ? HOLD : RAMP;
        end
      end
      if (rider_off_i) begin
        tgt_spd_d = '0;
      end else if (cmd_vld_i) begin
        tgt_spd_d = cmd_spd_i;
        tgt_rev_d = cmd_rev_i;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HOLD;
      out_spd_q <= '0;
      out_rev_q <= 1'b0;
      tgt_spd_q <= '0;
      tgt_rev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_spd_q <= out_spd_d;
      out_rev_q <= out_rev_d;
      tgt_spd_q <= tgt_spd_d;
      tgt_rev_q <= tgt_rev_d;
    end
  end

  assign out_spd_o  = out_spd_q;
  assign out_rev_o  = out_rev_q;
  assign rev_pend_o = (state_q == DECEL) || (state_q == FLIP);
  assign settled_o  = (state_q == HOLD) && (out_spd_q == tgt_spd_q) && (out_rev_q == tgt_rev_q);

endmodule

// File: rtl/spd_slew_ctrl.sv
// Multi-channel slew-limited motor command output stage: shared update tick,
// per-channel sequencers and an all-channels-settled indicator.
module spd_slew_ctrl
  import spd_slew_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int SPD_W     = 11,
  parameter int SLEW_STEP = 16,
  parameter int TICK_DIV  = 1024,
  parameter int fast_sim  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pwr_up,
  input  logic                    cmd_vld,
  input  logic [NUM_CH*SPD_W-1:0] cmd_spd,
  input  logic [NUM_CH-1:0]       cmd_rev,
  input  logic                    rider_off,
  output logic [NUM_CH*SPD_W-1:0] out_spd,
  output logic [NUM_CH-1:0]       out_rev,
  output logic [NUM_CH-1:0]       rev_pend,
  output logic                    settled
);

  localparam int DIV   = (fast_sim != 0) ? FAST_TICK_DIV : TICK_DIV;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic              cmd_load;
  logic [NUM_CH-1:0] ch_settled;

  assign tick     = (tick_cnt_q == CNT_W'(DIV - 1));
  assign cmd_load = cmd_vld && pwr_up && !rider_off;

  // Free-running tick divider; deliberately independent of pwr_up.
  always_comb begin
    tick_cnt_d = tick ? '0 : (tick_cnt_q + CNT_W'(1));
  end

  // Tick counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      spd_slew_ch #(
        .SPD_W     (SPD_W),
        .SLEW_STEP (SLEW_STEP)
      ) u_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwr_up_i    (pwr_up),
        .tick_i      (tick),
        .cmd_vld_i   (cmd_load),
        .rider_off_i (rider_off),
        .cmd_spd_i   (cmd_spd[gi*SPD_W +: SPD_W]),
        .cmd_rev_i   (cmd_rev[gi]),
        .out_spd_o   (out_spd[gi*SPD_W +: SPD_W]),
        .out_rev_o   (out_rev[gi]),
        .rev_pend_o  (rev_pend[gi]),
        .settled_o   (ch_settled[gi])
      );
    end
  endgenerate

  assign settled = &ch_settled;

endmodule
